// File: rtl/branch_rs.sv
// Branch reservation station: holds RV32I conditional branches until both operands arrive and resolves them oldest-first.
// Optional macro BRANCH_RS_STATS_EN adds the stat_resolved/stat_mispredicted handshake counters.
module branch_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [2:0]       dispatch_funct3,
  input  logic [TAG_W-1:0] dispatch_rob_tag,
  input  logic [31:0]      dispatch_pc,
  input  logic [31:0]      dispatch_imm,
  input  logic             dispatch_pred_taken,
  input  logic             rs1_ready,
  input  logic [31:0]      rs1_val,
  input  logic [TAG_W-1:0] rs1_tag,
  input  logic             rs2_ready,
  input  logic [31:0]      rs2_val,
  input  logic [TAG_W-1:0] rs2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_rob_tag,
  output logic             res_taken,
  output logic [31:0]      res_target,
  output logic [31:0]      res_next_pc,
  output logic             res_mispredict
`ifdef BRANCH_RS_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispredicted
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    logic             valid;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] robTag;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             predTaken;
    logic             rs1Rdy;
    logic [31:0]      rs1Val;
    logic [TAG_W-1:0] rs1Tag;
    logic             rs2Rdy;
    logic [31:0]      rs2Val;
    logic [TAG_W-1:0] rs2Tag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           cap   [DEPTH+1];
  entry_t           newEnt;
  entry_t           issueEnt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issueIdx;
  logic [CNT_W-1:0] slotAfterIssue;
  logic             issueFound;
  logic             issueFire;
  logic             doDispatch;
  logic             issueTaken;
  logic [31:0]      issueTarget;
  logic [31:0]      issueSeqPc;

  logic             resValid_q, resValid_d;
  logic [TAG_W-1:0] resTag_q, resTag_d;
  logic             resTaken_q, resTaken_d;
  logic [31:0]      resTarget_q, resTarget_d;
  logic [31:0]      resNextPc_q, resNextPc_d;
  logic             resMispredict_q, resMispredict_d;

  function automatic logic branchTaken(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // A waiting operand whose producer tag is on the CDB takes the broadcast value.
  function automatic entry_t snoop(input entry_t e,
                                   input logic v,
                                   input logic [TAG_W-1:0] t,
                                   input logic [31:0] val);
    entry_t r;
    r = e;
    if (v && e.valid) begin
      if (!e.rs1Rdy && (e.rs1Tag == t)) begin
        r.rs1Rdy = 1'b1;
        r.rs1Val = val;
      end
      if (!e.rs2Rdy && (e.rs2Tag == t)) begin
        r.rs2Rdy = 1'b1;
        r.rs2Val = val;
      end
    end
    return r;
  endfunction

  assign dispatch_ready = (count_q < DEPTH_C);
  assign issueFire      = issueFound && (!resValid_q || res_ready) && !flush;
  assign doDispatch     = dispatch_valid && dispatch_ready && !flush;
  assign slotAfterIssue = count_q - CNT_W'(issueFire);

  // Oldest ready entry wins; only registered ready bits count, so a CDB hit issues a cycle later.
  always_comb begin
    issueFound = 1'b0;
    issueIdx   = '0;
    issueEnt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!issueFound && ent_q[i].valid && ent_q[i].rs1Rdy && ent_q[i].rs2Rdy) begin
        issueFound = 1'b1;
        issueIdx   = CNT_W'(i);
        issueEnt   = ent_q[i];
      end
    end
  end

  always_comb begin
    newEnt           = '0;
    newEnt.valid     = 1'b1;
    newEnt.funct3    = dispatch_funct3;
    newEnt.robTag    = dispatch_rob_tag;
    newEnt.pc        = dispatch_pc;
    newEnt.imm       = dispatch_imm;
    newEnt.predTaken = dispatch_pred_taken;
    newEnt.rs1Rdy    = rs1_ready;
    newEnt.rs1Val    = rs1_val;
    newEnt.rs1Tag    = rs1_tag;
    newEnt.rs2Rdy    = rs2_ready;
    newEnt.rs2Val    = rs2_val;
    newEnt.rs2Tag    = rs2_tag;
    newEnt           = snoop(newEnt, cdb_valid, cdb_tag, cdb_value);
  end

  // Capture, then compact over the issued slot, then append the dispatch behind the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cap[i] = snoop(ent_q[i], cdb_valid, cdb_tag, cdb_value);
    end
    cap[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issueFire && (CNT_W'(i) >= issueIdx)) ? cap[i+1] : cap[i];
      if (doDispatch && (CNT_W'(i) == slotAfterIssue)) begin
        ent_d[i] = newEnt;
      end
      if (flush) begin
        ent_d[i] = '0;
      end
    end
    count_d = flush ? '0 : (slotAfterIssue + CNT_W'(doDispatch));
  end

  assign issueTaken  = branchTaken(issueEnt.funct3, issueEnt.rs1Val, issueEnt.rs2Val);
  assign issueTarget = issueEnt.pc + issueEnt.imm;
  assign issueSeqPc  = issueEnt.pc + 32'd4;

  always_comb begin
    resValid_d      = resValid_q;
    resTag_d        = resTag_q;
    resTaken_d      = resTaken_q;
    resTarget_d     = resTarget_q;
    resNextPc_d     = resNextPc_q;
    resMispredict_d = resMispredict_q;
    if (flush) begin
      resValid_d = 1'b0;
    end else if (issueFire) begin
      resValid_d      = 1'b1;
      resTag_d        = issueEnt.robTag;
      resTaken_d      = issueTaken;
      resTarget_d     = issueTarget;
      resNextPc_d     = issueTaken ? issueTarget : issueSeqPc;
      resMispredict_d = (issueTaken != issueEnt.predTaken);
    end else if (resValid_q && res_ready) begin
      resValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q         <= '0;
      resValid_q      <= 1'b0;
      resTag_q        <= '0;
      resTaken_q      <= 1'b0;
      resTarget_q     <= '0;
      resNextPc_q     <= '0;
      resMispredict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q         <= count_d;
      resValid_q      <= resValid_d;
      resTag_q        <= resTag_d;
      resTaken_q      <= resTaken_d;
      resTarget_q     <= resTarget_d;
      resNextPc_q     <= resNextPc_d;
      resMispredict_q <= resMispredict_d;
    end
  end

  assign res_valid      = resValid_q;
  assign res_rob_tag    = resTag_q;
  assign res_taken      = resTaken_q;
  assign res_target     = resTarget_q;
  assign res_next_pc    = resNextPc_q;
  assign res_mispredict = resMispredict_q;

`ifdef BRANCH_RS_STATS_EN
  logic [31:0] statResolved_q;
  logic [31:0] statMispredicted_q;

  // Flush does not clear these; they count every accepted resolution since reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      statResolved_q     <= '0;
      statMispredicted_q <= '0;
    end else if (resValid_q && res_ready) begin
      statResolved_q <= statResolved_q + 32'd1;
      if (resMispredict_q) begin
        statMispredicted_q <= statMispredicted_q + 32'd1;
      end
    end
  end

  assign stat_resolved     = statResolved_q;
  assign stat_mispredicted = statMispredicted_q;
`endif

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: stimulus pushes hand-computed resolutions, a negedge monitor pops and compares on each handshake.
module tb_branch_rs;

  localparam int TAG_W = 3;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [2:0]       dispatch_funct3;
  logic [TAG_W-1:0] dispatch_rob_tag;
  logic [31:0]      dispatch_pc;
  logic [31:0]      dispatch_imm;
  logic             dispatch_pred_taken;
  logic             rs1_ready;
  logic [31:0]      rs1_val;
  logic [TAG_W-1:0] rs1_tag;
  logic             rs2_ready;
  logic [31:0]      rs2_val;
  logic [TAG_W-1:0] rs2_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_rob_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic [31:0]      res_next_pc;
  logic             res_mispredict;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      nextPc;
    logic             misp;
  } result_t;

  result_t sbQ[$];
  int testsRun    = 0;
  int testsFailed = 0;

  branch_rs #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .dispatch_funct3     (dispatch_funct3),
    .dispatch_rob_tag    (dispatch_rob_tag),
    .dispatch_pc         (dispatch_pc),
    .dispatch_imm        (dispatch_imm),
    .dispatch_pred_taken (dispatch_pred_taken),
    .rs1_ready           (rs1_ready),
    .rs1_val             (rs1_val),
    .rs1_tag             (rs1_tag),
    .rs2_ready           (rs2_ready),
    .rs2_val             (rs2_val),
    .rs2_tag             (rs2_tag),
    .cdb_valid           (cdb_valid),
    .cdb_tag             (cdb_tag),
    .cdb_value           (cdb_value),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_rob_tag         (res_rob_tag),
    .res_taken           (res_taken),
    .res_target          (res_target),
    .res_next_pc         (res_next_pc),
    .res_mispredict      (res_mispredict)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectResult(input logic [TAG_W-1:0] tag, input logic taken,
                              input logic [31:0] target, input logic [31:0] nextPc,
                              input logic misp);
    result_t r;
    r.tag    = tag;
    r.taken  = taken;
    r.target = target;
    r.nextPc = nextPc;
    r.misp   = misp;
    sbQ.push_back(r);
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [TAG_W-1:0] tag,
                               input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                               input logic r1Rdy, input logic [31:0] r1Val, input logic [TAG_W-1:0] r1Tag,
                               input logic r2Rdy, input logic [31:0] r2Val, input logic [TAG_W-1:0] r2Tag);
    dispatch_funct3     = f3;
    dispatch_rob_tag    = tag;
    dispatch_pc         = pc;
    dispatch_imm        = imm;
    dispatch_pred_taken = pred;
    rs1_ready           = r1Rdy;
    rs1_val             = r1Val;
    rs1_tag             = r1Tag;
    rs2_ready           = r2Rdy;
    rs2_val             = r2Val;
    rs2_tag             = r2Tag;
    dispatch_valid      = 1'b1;
    tick();
    dispatch_valid      = 1'b0;
  endtask

  task automatic driveCdb(input logic [TAG_W-1:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = value;
    tick();
    cdb_valid = 1'b0;
  endtask

  // Monitor: every accepted resolution must match the oldest outstanding expectation.
  always @(negedge clk) begin
    result_t act;
    result_t expRes;
    if (rst && res_valid && res_ready) begin
      act = {res_rob_tag, res_taken, res_target, res_next_pc, res_mispredict};
      testsRun++;
      if (sbQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected result: got tag=%0d taken=%0d target=0x%0h next=0x%0h misp=%0d, expected none",
                 act.tag, act.taken, act.target, act.nextPc, act.misp);
      end else begin
        expRes = sbQ.pop_front();
        if (act !== expRes) begin
          testsFailed++;
          $display("[TB] FAIL result tag %0d: got tag=%0d taken=%0d target=0x%0h next=0x%0h misp=%0d, expected tag=%0d taken=%0d target=0x%0h next=0x%0h misp=%0d",
                   expRes.tag, act.tag, act.taken, act.target, act.nextPc, act.misp,
                   expRes.tag, expRes.taken, expRes.target, expRes.nextPc, expRes.misp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not reach its summary, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; dispatch_funct3 = '0;
    dispatch_rob_tag = '0; dispatch_pc = '0; dispatch_imm = '0; dispatch_pred_taken = 1'b0;
    rs1_ready = 1'b0; rs1_val = '0; rs1_tag = '0; rs2_ready = 1'b0; rs2_val = '0; rs2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; res_ready = 1'b1;

    // Reset
    tick(); tick();
    rst = 1'b1;
    checkOutput("reset res_valid", res_valid, 1'b0);
    checkOutput("reset dispatch_ready", dispatch_ready, 1'b1);
    checkOutput("reset res_rob_tag", res_rob_tag, 0);
    checkOutput("reset res_taken", res_taken, 1'b0);
    checkOutput("reset res_target", res_target, 0);
    checkOutput("reset res_next_pc", res_next_pc, 0);
    checkOutput("reset res_mispredict", res_mispredict, 1'b0);

    // Taken beq, predicted not taken; latency of two cycles
    expectResult(3'd1, 1'b1, 32'h120, 32'h120, 1'b1);
    applyStimulus(BEQ, 3'd1, 32'h100, 32'h20, 1'b0, 1'b1, 32'd5, 3'd0, 1'b1, 32'd5, 3'd0);
    checkOutput("beq latency cycle1 res_valid", res_valid, 1'b0);
    tick();
    checkOutput("beq latency cycle2 res_valid", res_valid, 1'b1);
    tick();
    checkOutput("beq drained res_valid", res_valid, 1'b0);

    // Signed/unsigned compares, undefined funct3 and 32-bit wrap, back to back
    expectResult(3'd2, 1'b1, 32'h210, 32'h210, 1'b1);
    expectResult(3'd3, 1'b0, 32'h210, 32'h204, 1'b0);
    expectResult(3'd5, 1'b0, 32'h210, 32'h204, 1'b1);
    expectResult(3'd6, 1'b1, 32'h10, 32'h10, 1'b0);
    expectResult(3'd7, 1'b0, 32'h4, 32'h0, 1'b0);
    applyStimulus(BLT,  3'd2, 32'h200, 32'h10, 1'b0, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    applyStimulus(BLTU, 3'd3, 32'h200, 32'h10, 1'b0, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    applyStimulus(BGE,  3'd5, 32'h200, 32'h10, 1'b1, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    applyStimulus(BGEU, 3'd6, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    applyStimulus(3'b010, 3'd7, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b1, 32'd3, 3'd0, 1'b1, 32'd3, 3'd0);
    tick(); tick();
    checkOutput("compare group drained", res_valid, 1'b0);

    // bne waiting on tag 3; wrong-tag broadcast must not wake it
    expectResult(3'd4, 1'b0, 32'h340, 32'h304, 1'b1);
    applyStimulus(BNE, 3'd4, 32'h300, 32'h40, 1'b1, 1'b0, 32'hDEAD, 3'd3, 1'b1, 32'd7, 3'd0);
    checkOutput("cdb wait d+1", res_valid, 1'b0);
    tick();
    checkOutput("cdb wait d+2", res_valid, 1'b0);
    driveCdb(3'd5, 32'd7);
    checkOutput("cdb wrong tag no wake", res_valid, 1'b0);
    driveCdb(3'd3, 32'd7);
    checkOutput("cdb broadcast +1", res_valid, 1'b0);
    tick();
    checkOutput("cdb broadcast +2", res_valid, 1'b1);
    checkOutput("cdb bne taken", res_taken, 1'b0);
    tick();

    // Dispatch captures a same-cycle broadcast
    expectResult(3'd5, 1'b1, 32'h3F0, 32'h3F0, 1'b0);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'd9;
    applyStimulus(BEQ, 3'd5, 32'h400, 32'hFFFFFFF0, 1'b1, 1'b0, 32'd0, 3'd2, 1'b1, 32'd9, 3'd0);
    cdb_valid = 1'b0;
    checkOutput("same-cycle capture d+1", res_valid, 1'b0);
    tick();
    checkOutput("same-cycle capture d+2", res_valid, 1'b1);
    tick();

    // Both operands woken by one broadcast
    expectResult(3'd6, 1'b1, 32'h508, 32'h508, 1'b1);
    applyStimulus(BEQ, 3'd6, 32'h500, 32'h8, 1'b0, 1'b0, 32'd0, 3'd1, 1'b0, 32'd0, 3'd1);
    driveCdb(3'd1, 32'h55);
    checkOutput("dual wake +1", res_valid, 1'b0);
    tick();
    checkOutput("dual wake +2", res_valid, 1'b1);
    tick();

    // Backpressure: exactly five accepted, then in-order drain at one per cycle
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("bp dispatch_ready %0d", i), dispatch_ready, (i < 5) ? 1'b1 : 1'b0);
      if (i < 5) expectResult(TAG_W'(i), 1'b1, 32'h1008 + 32'(16 * i), 32'h1008 + 32'(16 * i), 1'b0);
      applyStimulus(BEQ, TAG_W'(i), 32'h1000 + 32'(16 * i), 32'h8, 1'b1,
                    1'b1, 32'(i), 3'd0, 1'b1, 32'(i), 3'd0);
    end
    checkOutput("bp full dispatch_ready", dispatch_ready, 1'b0);
    checkOutput("bp held res_valid", res_valid, 1'b1);
    tick(); tick();
    checkOutput("bp stable res_rob_tag", res_rob_tag, 0);
    checkOutput("bp stable res_target", res_target, 32'h1008);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("drain %0d res_valid", k), res_valid, 1'b1);
      checkOutput($sformatf("drain %0d res_rob_tag", k), res_rob_tag, k);
      tick();
    end
    checkOutput("drain done res_valid", res_valid, 1'b0);
    checkOutput("drain done dispatch_ready", dispatch_ready, 1'b1);

    // Flush with three waiting entries and a held result; dispatch in the flush cycle is dropped
    res_ready = 1'b0;
    applyStimulus(BEQ, 3'd0, 32'h600, 32'h10, 1'b0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(BEQ, TAG_W'(i), 32'h600, 32'h10, 1'b0, 1'b0, 32'd0, 3'd6, 1'b1, 32'd2, 3'd0);
    end
    checkOutput("pre-flush res_valid", res_valid, 1'b1);
    flush = 1'b1;
    applyStimulus(BEQ, 3'd7, 32'h700, 32'h10, 1'b0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    flush = 1'b0;
    checkOutput("post-flush res_valid", res_valid, 1'b0);
    checkOutput("post-flush dispatch_ready", dispatch_ready, 1'b1);
    res_ready = 1'b1;
    driveCdb(3'd6, 32'd2);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("post-flush quiet %0d", i), res_valid, 1'b0);
      tick();
    end

    // Reset mid-operation discards the held result and waiting entries
    res_ready = 1'b0;
    applyStimulus(BNE, 3'd2, 32'h800, 32'h10, 1'b0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0);
    tick();
    checkOutput("pre-reset res_valid", res_valid, 1'b1);
    applyStimulus(BEQ, 3'd3, 32'h900, 32'h10, 1'b0, 1'b0, 32'd0, 3'd4, 1'b1, 32'd0, 3'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("mid-reset res_valid", res_valid, 1'b0);
    checkOutput("mid-reset res_target", res_target, 0);
    checkOutput("mid-reset res_taken", res_taken, 1'b0);
    checkOutput("mid-reset dispatch_ready", dispatch_ready, 1'b1);
    res_ready = 1'b1;
    driveCdb(3'd4, 32'd0);
    tick();
    checkOutput("mid-reset quiet", res_valid, 1'b0);
    tick();

    checkOutput("scoreboard empty", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
